fu_mult_wb: RTL and testbench

- Writeback-side controller for the pipelined multiplier functional unit; it is the consumer end of the multiplier's enable/done interface.
- Accepts issue requests carrying a destination tag and drives the multiplier's enable and function code.
- Carries each tag through a fixed-latency shadow pipeline and captures the result on done.
- Buffers {tag, result} in a small FIFO and presents it to the CDB under a valid/grant handshake. Credit-based issue_ready guarantees the FIFO never overflows.

---
 rtl/fu_mult_wb.sv | 120 ++++++++++++
 tb/tb_fu_mult_wb.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_mult_wb.sv
// Writeback-side controller for the pipelined multiplier: issues ops, shadows their tags
// for LAT cycles, captures results on done and buffers them for the CDB.
module fu_mult_wb #(
    parameter int XLEN  = 32,
    parameter int LAT   = 4,
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             squash,
    input  logic             issue_valid,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic [4:0]       issue_func,
    output logic             issue_ready,
    output logic             mult_en,
    output logic [4:0]       mult_func,
    input  logic [XLEN-1:0]  mult_result,
    input  logic             mult_done,
    output logic             cdb_valid,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [XLEN-1:0]  cdb_value,
    input  logic             cdb_grant,
    output logic             sync_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = $clog2(DEPTH + LAT + 1) + 1;

    // Handshakes: a transfer happens on a cycle where valid & ready (issue) or
    // valid & grant (CDB) are both high; neither side may make valid depend on ready/grant.
    logic [LAT-1:0]   pipe_vld_q, pipe_vld_d;
    logic [TAG_W-1:0] pipe_tag_q [LAT];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             sync_err_q, sync_err_d;
    logic [TAG_W-1:0] mem_tag_q [DEPTH];
    logic [XLEN-1:0]  mem_val_q [DEPTH];

    logic [SW-1:0] inflight;
    logic [SW-1:0] credit_sum;
    logic          tail_vld, fifo_full, fifo_empty;
    logic          pop, capture, push, overflow, missing;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + SW'(pipe_vld_q[i]);
        end
    end

    // Credit counts every op that may still land in the FIFO; a same-cycle pop is ignored.
    assign credit_sum  = SW'(count_q) + inflight;
    assign issue_ready = ~reset & ~squash & (credit_sum < SW'(DEPTH));
    assign mult_en     = issue_valid & issue_ready;
    assign mult_func   = issue_func;

    assign tail_vld   = pipe_vld_q[LAT-1];
    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_empty = (count_q == '0);

    assign pop      = ~squash & ~fifo_empty & cdb_grant;
    assign capture  = ~squash & tail_vld & mult_done;
    assign push     = capture & (~fifo_full | pop);
    assign overflow = capture & fifo_full & ~pop;
    assign missing  = ~squash & tail_vld & ~mult_done;

    always_comb begin
        pipe_vld_d    = '0;
        pipe_vld_d[0] = mult_en;
        for (int i = 1; i < LAT; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
        end
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        wr_ptr_d   = wr_ptr_q + PW'(push);
        count_d    = count_q + CW'(push) - CW'(pop);
        sync_err_d = sync_err_q | missing | overflow;
        if (squash) begin
            pipe_vld_d = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pipe_vld_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            sync_err_q <= 1'b0;
        end else begin
            pipe_vld_q <= pipe_vld_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            sync_err_q <= sync_err_d;
        end
    end

    // Payload storage carries no reset; the valid bits and count qualify it.
    always_ff @(posedge clock) begin
        pipe_tag_q[0] <= issue_tag;
        for (int i = 1; i < LAT; i++) begin
            pipe_tag_q[i] <= pipe_tag_q[i-1];
        end
        if (push) begin
            mem_tag_q[wr_ptr_q] <= pipe_tag_q[LAT-1];
            mem_val_q[wr_ptr_q] <= mult_result;
        end
    end

    assign cdb_valid = ~reset & ~fifo_empty;
    assign cdb_tag   = fifo_empty ? '0 : mem_tag_q[rd_ptr_q];
    assign cdb_value = fifo_empty ? '0 : mem_val_q[rd_ptr_q];
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_fu_mult_wb.sv
// Bench for fu_mult_wb: a stand-in multiplier, a queue-based model of issue/retire,
// a per-cycle compare process and directed scenarios with literal expectations.
module tb_fu_mult_wb;
    localparam int XLEN  = 32;
    localparam int LAT   = 4;
    localparam int DEPTH = 4;
    localparam int TAG_W = 6;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             squash = 1'b0;
    logic             issue_valid = 1'b0;
    logic [TAG_W-1:0] issue_tag = '0;
    logic [4:0]       issue_func = '0;
    logic             issue_ready, mult_en;
    logic [4:0]       mult_func;
    logic [XLEN-1:0]  mult_result;
    logic             mult_done;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_value;
    logic             cdb_grant = 1'b0;
    logic             sync_err;

    fu_mult_wb #(.XLEN(XLEN), .LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .issue_valid(issue_valid), .issue_tag(issue_tag), .issue_func(issue_func),
        .issue_ready(issue_ready), .mult_en(mult_en), .mult_func(mult_func),
        .mult_result(mult_result), .mult_done(mult_done),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .cdb_grant(cdb_grant), .sync_err(sync_err)
    );

    // Clock / cycle bookkeeping
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stand-in multiplier: fixed LAT-cycle latency, result chosen by the driver at issue.
    logic [XLEN-1:0] next_result = '0;
    bit              suppress_done = 1'b0;
    bit              done_sr [LAT];
    bit [XLEN-1:0]   res_sr  [LAT];

    always @(posedge clock) begin
        for (int i = LAT - 1; i > 0; i--) begin
            done_sr[i] <= done_sr[i-1];
            res_sr[i]  <= res_sr[i-1];
        end
        done_sr[0] <= mult_en & ~suppress_done;
        res_sr[0]  <= next_result;
    end
    assign mult_done   = done_sr[LAT-1];
    assign mult_result = res_sr[LAT-1];

    // Model: ops waiting for their result (tag + issue cycle) and the expected CDB queue.
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        int               cyc;
    } pend_t;
    pend_t                     m_pend[$];
    logic [TAG_W+XLEN-1:0]     exp_q[$];
    bit                        m_err = 1'b0;

    function automatic bit m_ready();
        return !reset && !squash && ((exp_q.size() + m_pend.size()) < DEPTH);
    endfunction

    always @(posedge clock) begin : model
        bit en;
        bit due;
        en = issue_valid && m_ready();
        if (reset) begin
            m_pend.delete();
            exp_q.delete();
            m_err = 1'b0;
        end else if (squash) begin
            m_pend.delete();
            exp_q.delete();
        end else begin
            due = (m_pend.size() != 0) && (m_pend[0].cyc + LAT == cyc);
            if (exp_q.size() != 0 && cdb_grant) void'(exp_q.pop_front());
            if (due) begin
                if (!mult_done) m_err = 1'b1;
                else if (exp_q.size() < DEPTH) exp_q.push_back({m_pend[0].tag, mult_result});
                else m_err = 1'b1;
                void'(m_pend.pop_front());
            end
            if (en) m_pend.push_back('{tag: issue_tag, cyc: cyc});
        end
        cyc++;
    end

    // Scoreboard compare, mid-cycle
    always @(negedge clock) begin
        if (chk_en) begin
            bit                    e_ready;
            logic [TAG_W+XLEN-1:0] e_head;
            e_ready = m_ready();
            chk("issue_ready", issue_ready, e_ready);
            chk("mult_en", mult_en, issue_valid & e_ready);
            chk("mult_func", mult_func, issue_func);
            chk("cdb_valid", cdb_valid, !reset && exp_q.size() != 0);
            chk("sync_err", sync_err, m_err);
            if (!reset) begin
                e_head = (exp_q.size() != 0) ? exp_q[0] : '0;
                chk("cdb_tag", cdb_tag, e_head[TAG_W+XLEN-1:XLEN]);
                chk("cdb_value", cdb_value, e_head[XLEN-1:0]);
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic set_issue(input bit v, input int tag, input int res, input bit sup);
        issue_valid   = v;
        issue_tag     = TAG_W'(tag);
        issue_func    = 5'(tag + 1);
        next_result   = XLEN'(res);
        suppress_done = sup;
    endtask

    initial begin
        int acc;
        int tag;

        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst_issue_ready", issue_ready, 1);
        chk("rst_cdb_valid", cdb_valid, 0);
        chk("rst_sync_err", sync_err, 0);

        // Single op: result visible LAT+1 cycles after issue, popped the same cycle.
        cdb_grant = 1'b1;
        set_issue(1, 5, 'h15, 0);
        tick();
        set_issue(0, 0, 0, 0);
        ticks(4);
        chk("single_valid", cdb_valid, 1);
        chk("single_tag", cdb_tag, 5);
        chk("single_value", cdb_value, 'h15);
        tick();
        chk("single_empty", cdb_valid, 0);

        // Backpressure: credit limits acceptance to DEPTH ops.
        cdb_grant = 1'b0;
        acc = 0;
        tag = 1;
        for (int i = 0; i < 12; i++) begin
            set_issue(tag <= 6, tag, 'h100 + tag, 0);
            #1;
            if (mult_en) begin
                acc++;
                tag++;
            end
            tick();
        end
        set_issue(0, 0, 0, 0);
        #1;
        chk("bp_accepted", acc, 4);
        chk("bp_ready_low", issue_ready, 0);
        chk("bp_head", cdb_tag, 1);
        cdb_grant = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("bp_drain_tag", cdb_tag, i);
            chk("bp_drain_value", cdb_value, 'h100 + i);
            tick();
        end
        chk("bp_drained", cdb_valid, 0);
        chk("bp_ready_back", issue_ready, 1);

        // Simultaneous push and pop with 3 buffered + 1 arriving.
        cdb_grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_issue(1, 10 + i, 'h200 + i, 0);
            tick();
        end
        set_issue(0, 0, 0, 0);
        ticks(3);
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;
        #1;
        chk("pp_valid", cdb_valid, 1);
        chk("pp_head", cdb_tag, 11);
        cdb_grant = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            chk("pp_order", cdb_tag, 10 + i);
            chk("pp_value", cdb_value, 'h200 + i);
            tick();
        end
        chk("pp_empty", cdb_valid, 0);

        // Squash with 2 buffered and 2 in flight.
        cdb_grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_issue(1, 20 + i, 'h300 + i, 0);
            tick();
        end
        set_issue(0, 0, 0, 0);
        ticks(2);
        squash = 1'b1;
        #1;
        chk("sq_ready_low", issue_ready, 0);
        tick();
        squash = 1'b0;
        chk("sq_cdb_valid", cdb_valid, 0);
        ticks(3);
        chk("sq_sync_err", sync_err, 0);
        cdb_grant = 1'b1;
        set_issue(1, 30, 'h3030, 0);
        tick();
        set_issue(0, 0, 0, 0);
        ticks(4);
        chk("sq_new_tag", cdb_tag, 30);
        chk("sq_new_value", cdb_value, 'h3030);
        tick();
        chk("sq_new_popped", cdb_valid, 0);

        // Missing done sets a sticky error and buffers nothing.
        set_issue(1, 9, 'h99, 1);
        tick();
        set_issue(0, 0, 0, 0);
        ticks(4);
        chk("miss_err", sync_err, 1);
        chk("miss_no_entry", cdb_valid, 0);
        ticks(3);
        chk("miss_sticky", sync_err, 1);

        // Reset in the middle of an op.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_issue(1, 7, 'h77, 0);
        tick();
        set_issue(0, 0, 0, 0);
        tick();
        reset = 1'b1;
        #1;
        chk("rm_ready_in_reset", issue_ready, 0);
        chk("rm_valid_in_reset", cdb_valid, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("rm_cleared_valid", cdb_valid, 0);
        chk("rm_cleared_err", sync_err, 0);
        ticks(2);
        chk("rm_done_ignored_err", sync_err, 0);
        chk("rm_done_ignored_valid", cdb_valid, 0);

        // Mixed traffic against the model.
        for (int i = 0; i < 80; i++) begin
            set_issue($urandom_range(0, 3) != 0, $urandom_range(0, 63),
                      $urandom_range(0, 32'h7fff_ffff), 0);
            cdb_grant = ($urandom_range(0, 2) != 0);
            squash    = ($urandom_range(0, 24) == 0);
            tick();
        end
        set_issue(0, 0, 0, 0);
        squash    = 1'b0;
        cdb_grant = 1'b1;
        ticks(12);
        chk("mix_drained", cdb_valid, 0);
        chk("mix_no_err", sync_err, 0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
